fpu_result_collector: RTL and testbench

Result-side companion to the FPU interface. The FPU instruction driver issues `fpu_instruction_t` words into the FPU pipeline; this block tracks each issue through a fixed-latency shadow pipeline. When the issue emerges, it captures `out` and the eight status flags into a tagged record and buffers the records in a FIFO, drained by a valid/ready consumer (scoreboard or writeback). It also returns credit-based backpressure to the issuer, so a compliant issuer never loses a result.

---
 rtl/fpu_result_collector_if.sv | 46 ++++
 rtl/fpu_result_collector.sv | 138 +++++++++++++
 tb/tb_fpu_result_collector.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_result_collector_if.sv
// Issue, FPU-result and record bundle for fpu_result_collector.
// master = issuer/FPU/consumer side, slave = collector.
interface fpu_result_collector_if;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [1:0]  issue_rmode;
  logic        issue_ready;
  logic [31:0] out;
  logic        inf;
  logic        snan;
  logic        qnan;
  logic        ine;
  logic        overflow;
  logic        underflow;
  logic        zero;
  logic        div_by_zero;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_result;
  logic [7:0]  rec_flags;
  logic [2:0]  rec_op;
  logic [1:0]  rec_rmode;
  logic [7:0]  rec_seq;
  logic        drop_sticky;
  logic [7:0]  drop_count;

  modport master (
    output issue_valid, issue_op, issue_rmode,
    output out, inf, snan, qnan, ine,
    output overflow, underflow, zero, div_by_zero,
    output rec_ready,
    input  issue_ready, rec_valid, rec_result,
    input  rec_flags, rec_op, rec_rmode, rec_seq,
    input  drop_sticky, drop_count
  );

  modport slave (
    input  issue_valid, issue_op, issue_rmode,
    input  out, inf, snan, qnan, ine,
    input  overflow, underflow, zero, div_by_zero,
    input  rec_ready,
    output issue_ready, rec_valid, rec_result,
    output rec_flags, rec_op, rec_rmode, rec_seq,
    output drop_sticky, drop_count
  );
endinterface

// File: rtl/fpu_result_collector.sv
// Shadows FPU issues, captures tagged results into a FWFT FIFO with credits.
// Optional FPU_COLLECT_SEQ_EN adds the 8-bit issue sequence tag.
module fpu_result_collector #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input logic                   clk,
  input logic                   reset,
  fpu_result_collector_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(LATENCY + 1);

  logic          r_sv  [LATENCY];
  logic [2:0]    r_sop [LATENCY];
  logic [1:0]    r_srm [LATENCY];
  logic [IW-1:0] r_inflight;
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [31:0]   r_mres [DEPTH];
  logic [7:0]    r_mflg [DEPTH];
  logic [2:0]    r_mop  [DEPTH];
  logic [1:0]    r_mrm  [DEPTH];
  logic          r_drop;
  logic [7:0]    r_dcnt;

  logic          w_cap;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW-1:0] w_wa;
  logic [AW-1:0] w_ra;
  logic [PW-1:0] w_count;
  logic [7:0]    w_credit;
  logic [7:0]    w_flags;

  assign w_cap   = r_sv[LATENCY-1];
  assign w_wa    = r_wr[AW-1:0];
  assign w_ra    = r_rd[AW-1:0];
  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (w_wa == w_ra);
  assign w_pop   = ~w_empty & bus.rec_ready;
  // A pop on the same edge makes room, so a full FIFO still takes the push.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & ~w_push;
  assign w_count = r_wr - r_rd;

  assign w_flags = {bus.div_by_zero, bus.zero, bus.underflow,
                    bus.overflow, bus.ine, bus.qnan,
                    bus.snan, bus.inf};

  assign w_credit        = 8'(r_inflight) + 8'(w_count);
  assign bus.issue_ready = (w_credit < 8'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_sv[i]  <= 1'b0;
        r_sop[i] <= '0;
        r_srm[i] <= '0;
      end
      r_inflight <= '0;
    end else begin
      r_sv[0]  <= bus.issue_valid;
      r_sop[0] <= bus.issue_op;
      r_srm[0] <= bus.issue_rmode;
      for (int i = 1; i < LATENCY; i++) begin
        r_sv[i]  <= r_sv[i-1];
        r_sop[i] <= r_sop[i-1];
        r_srm[i] <= r_srm[i-1];
      end
      r_inflight <= r_inflight + IW'(bus.issue_valid)
                  - IW'(w_cap);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_drop <= 1'b0;
      r_dcnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      if (w_drop) begin
        r_drop <= 1'b1;
        if (r_dcnt != 8'hFF) r_dcnt <= r_dcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mres[w_wa] <= bus.out;
      r_mflg[w_wa] <= w_flags;
      r_mop[w_wa]  <= r_sop[LATENCY-1];
      r_mrm[w_wa]  <= r_srm[LATENCY-1];
    end
  end

  assign bus.rec_valid   = ~w_empty;
  assign bus.rec_result  = w_empty ? '0 : r_mres[w_ra];
  assign bus.rec_flags   = w_empty ? '0 : r_mflg[w_ra];
  assign bus.rec_op      = w_empty ? '0 : r_mop[w_ra];
  assign bus.rec_rmode   = w_empty ? '0 : r_mrm[w_ra];
  assign bus.drop_sticky = r_drop;
  assign bus.drop_count  = r_dcnt;

`ifdef FPU_COLLECT_SEQ_EN
  logic [7:0] r_seq;
  logic [7:0] r_sseq [LATENCY];
  logic [7:0] r_mseq [DEPTH];

  // Counts every issue, credited or not: the FPU itself never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seq <= '0;
      for (int i = 0; i < LATENCY; i++) r_sseq[i] <= '0;
    end else begin
      if (bus.issue_valid) r_seq <= r_seq + 8'd1;
      r_sseq[0] <= r_seq;
      for (int i = 1; i < LATENCY; i++) r_sseq[i] <= r_sseq[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mseq[w_wa] <= r_sseq[LATENCY-1];
  end

  assign bus.rec_seq = w_empty ? '0 : r_mseq[w_ra];
`else
  assign bus.rec_seq = '0;
`endif
endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector with an in-order record scoreboard.
// Sequence expectations follow FPU_COLLECT_SEQ_EN.
module tb_fpu_result_collector;
  localparam int LAT = 4;
  localparam int DEP = 8;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RZ  = 2'd1;
  localparam logic [1:0] RUP = 2'd2;
  localparam logic [1:0] RDN = 2'd3;

  typedef struct packed {
    logic [31:0] res;
    logic [7:0]  flg;
    logic [2:0]  op;
    logic [1:0]  rm;
    logic [7:0]  seq;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fpu_result_collector_if bus();

  fpu_result_collector #(
    .LATENCY(LAT),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // Stand-in FPU: result and flags are a function of the capture cycle.
  logic        ovr = 1'b0;
  logic [31:0] ovr_out = 32'd0;
  logic [7:0]  ovr_flg = 8'd0;
  logic [7:0]  w_fl;
  assign bus.out = ovr ? ovr_out : {16'hA5A5, cyc};
  assign w_fl    = ovr ? ovr_flg : cyc[7:0];
  assign bus.inf         = w_fl[0];
  assign bus.snan        = w_fl[1];
  assign bus.qnan        = w_fl[2];
  assign bus.ine         = w_fl[3];
  assign bus.overflow    = w_fl[4];
  assign bus.underflow   = w_fl[5];
  assign bus.zero        = w_fl[6];
  assign bus.div_by_zero = w_fl[7];

  int n_chk = 0;
  int n_fail = 0;
  int issue_no = 0;
  logic [7:0] last_seq = 8'd0;
  rec_t q[$];

  function automatic logic [7:0] exp_seq(input int n);
`ifdef FPU_COLLECT_SEQ_EN
    return 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [2:0] op,
                      input logic [1:0] rm, input logic rr,
                      input logic keep);
    rec_t e;
    rec_t h;
    bus.issue_valid = iv;
    bus.issue_op    = op;
    bus.issue_rmode = rm;
    bus.rec_ready   = rr;
    if (iv && keep) begin
      e.res = {16'hA5A5, cyc + 16'(LAT)};
      e.flg = 8'(cyc + 16'(LAT));
      e.op  = op;
      e.rm  = rm;
      e.seq = exp_seq(issue_no);
      q.push_back(e);
    end
    if (iv) issue_no++;
    if (bus.rec_valid && rr) begin
      chk("rec_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        h = q.pop_front();
        chk("rec_fields",
            64'({bus.rec_result, bus.rec_flags, bus.rec_op,
                 bus.rec_rmode, bus.rec_seq}),
            64'(h));
        last_seq = bus.rec_seq;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.issue_valid = 1'b0;
    bus.issue_op    = OP_ADD;
    bus.issue_rmode = RNE;
    bus.rec_ready   = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rec_valid", 64'(bus.rec_valid), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
    chk("rst_drop_sticky", 64'(bus.drop_sticky), 64'd0);
    chk("rst_rec_result", 64'(bus.rec_result), 64'd0);
    chk("rst_rec_seq", 64'(bus.rec_seq), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single MULT issue, result 0x40490FDB with ine in cycle t+4.
    q.push_back(rec_t'{32'h40490FDB, 8'h08, OP_MULT, RNE,
                       exp_seq(issue_no)});
    step(1'b1, OP_MULT, RNE, 1'b1, 1'b0);
    repeat (LAT - 1) step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    ovr_out = 32'h40490FDB;
    ovr_flg = 8'h08;
    ovr = 1'b1;
    chk("t1_not_early", 64'(bus.rec_valid), 64'd0);
    step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    ovr = 1'b0;
    chk("t1_valid_t5", 64'(bus.rec_valid), 64'd1);
    step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t1_drained", 64'(bus.rec_valid), 64'd0);
    chk("t1_seq", 64'(last_seq), 64'd0);

    // Eight back-to-back issues into a stalled consumer.
    for (int k = 0; k < DEP; k++) begin
      chk("t2_ready_high", 64'(bus.issue_ready), 64'd1);
      step(1'b1, OP_MULT, 2'(k), 1'b0, 1'b1);
    end
    chk("t2_ready_low", 64'(bus.issue_ready), 64'd0);
    repeat (LAT + 1) step(1'b0, OP_ADD, RNE, 1'b0, 1'b0);
    chk("t2_rec_valid", 64'(bus.rec_valid), 64'd1);
    chk("t2_still_low", 64'(bus.issue_ready), 64'd0);
    chk("t2_drop_count", 64'(bus.drop_count), 64'd0);
    chk("t2_drop_sticky", 64'(bus.drop_sticky), 64'd0);

    // Ninth issue against a full FIFO with no pop: dropped.
    step(1'b1, OP_ADD, RZ, 1'b0, 1'b0);
    repeat (LAT - 1) step(1'b0, OP_ADD, RNE, 1'b0, 1'b0);
    chk("t3_no_drop_yet", 64'(bus.drop_sticky), 64'd0);
    step(1'b0, OP_ADD, RNE, 1'b0, 1'b0);
    chk("t3_drop_sticky", 64'(bus.drop_sticky), 64'd1);
    chk("t3_drop_count", 64'(bus.drop_count), 64'd1);

    // Full FIFO with a pop on the capture edge: push accepted.
    step(1'b1, OP_SUB, RUP, 1'b0, 1'b1);
    repeat (LAT - 1) step(1'b0, OP_ADD, RNE, 1'b0, 1'b0);
    step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t4_drop_count", 64'(bus.drop_count), 64'd1);
    chk("t4_full_ready", 64'(bus.issue_ready), 64'd0);
    chk("t4_rec_valid", 64'(bus.rec_valid), 64'd1);
    repeat (DEP) step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t4_empty", 64'(bus.rec_valid), 64'd0);
    chk("t4_ready_back", 64'(bus.issue_ready), 64'd1);
    chk("t4_all_seen", 64'(q.size()), 64'd0);

    // Reset pulse with three records in flight.
    for (int k = 0; k < 3; k++) step(1'b1, OP_MULT, RNE, 1'b0, 1'b1);
    repeat (3) step(1'b0, OP_ADD, RNE, 1'b0, 1'b0);
    chk("t6_pre_valid", 64'(bus.rec_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(bus.rec_valid), 64'd0);
    chk("t6_rst_result", 64'(bus.rec_result), 64'd0);
    chk("t6_rst_ready", 64'(bus.issue_ready), 64'd1);
    chk("t6_rst_dcount", 64'(bus.drop_count), 64'd0);
    chk("t6_rst_sticky", 64'(bus.drop_sticky), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    issue_no = 0;
    repeat (LAT + 4) step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t6_no_stale", 64'(bus.rec_valid), 64'd0);
    last_seq = 8'hFF;
    step(1'b1, OP_SUB, RDN, 1'b1, 1'b1);
    repeat (LAT + 1) step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t6_first_seq", 64'(last_seq), 64'd0);
    chk("t6_drained", 64'(q.size()), 64'd0);

    // 300 streamed issues: sequence wraps, last is 300 mod 256.
    repeat (300) step(1'b1, OP_ADD, RNE, 1'b1, 1'b1);
    repeat (LAT + 2) step(1'b0, OP_ADD, RNE, 1'b1, 1'b0);
    chk("t5_last_seq", 64'(last_seq), 64'(exp_seq(300)));
    chk("t5_drained", 64'(q.size()), 64'd0);
    chk("t5_ready", 64'(bus.issue_ready), 64'd1);
    chk("t5_no_drop", 64'(bus.drop_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
